vga_scan_ctrl: RTL



---
 rtl/vga_scan_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA 640x480@60 raster engine.
// A request stage drives the renderer with (x, y), one pixel ahead of the display.
// An output stage latches the renderer colour together with sync/blanking, all
// aligned to the pixel that was just requested.
`timescale 1ns/1ps
module vga_scan_ctrl #(
    parameter int DIV       = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] data,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        video_on,
    output logic        frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             strobe;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             pix_vis;

    // Pixel strobe: last clk of each DIV-clk pixel period.
    always_comb begin
        strobe = (div_cnt == DIV_LAST);
    end

    // Raster position after the coming strobe, with line and frame wrap.
    always_comb begin
        h_next = h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    // The pixel currently requested is the one the output stage latches next.
    always_comb begin
        pix_vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    end

    // Clock divider producing the pixel rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Request stage: raster counters and the coordinates sent to the renderer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
            x     <= '0;
            y     <= '0;
        end else if (strobe) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            x     <= (h_next < H_VIS) ? h_next : '0;
            y     <= (v_next < V_VIS) ? v_next[8:0] : '0;
        end
    end

    // Output stage: colour and syncs for the pixel requested one strobe earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_on  <= 1'b0;
            {r, g, b} <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else if (strobe) begin
            video_on  <= pix_vis;
            {r, g, b} <= pix_vis ? data : 12'h000;
            hsync     <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
            vsync     <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
        end
    end

    // One-clk tick as the first line of the vertical front porch is displayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= strobe && (h_cnt == '0) && (v_cnt == V_VIS);
        end
    end

endmodule
